urng_pair_packer: RTL and testbench

//  Downstream of the 3-component Tausworthe URNG in the AWGN chain. Packs two successive
//  32-bit uniform words into one Box-Muller operand pair (u0 48b, u1 16b), guards u0 against zero,
//  and buffers pairs in a small FIFO with a valid/ready interface to the Box-Muller stage.

---
 rtl/awgn_pkg.sv | 37 +++
 rtl/awgn_pair_fifo.sv | 95 +++++++++
 rtl/urng_pair_packer.sv | 173 +++++++++++++++++
 tb/tb_urng_pair_packer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : awgn_pkg
//  Description : Shared types and helpers for the AWGN chain. Carries the
//                Box-Muller operand pair layout (u0 48b, u1 16b), the URNG
//                word width, the packer phase encoding and the u0 zero guard.
//                Shared with the Box-Muller stage.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package awgn_pkg;

   localparam int U0_W   = 48;
   localparam int U1_W   = 16;
   localparam int URNG_W = 32;

   // One Box-Muller operand pair as stored in the pair FIFO.
   typedef struct packed {
      logic [U0_W-1:0] u0;
      logic [U1_W-1:0] u1;
   } bm_pair_t;

   // Packing phase: HI waits for the word that becomes u0[47:16],
   // LO waits for the word that completes the pair.
   typedef enum logic [0:0] {
      PH_HI = 1'b0,
      PH_LO = 1'b1
   } pack_phase_t;

   // ln(u0) downstream is undefined at zero, so the smallest non-zero
   // value replaces an all-zero operand.
   function automatic logic [U0_W-1:0] u0_guard(input logic [U0_W-1:0] u0_raw);
      return (u0_raw == '0) ? U0_W'(1) : u0_raw;
   endfunction

endpackage : awgn_pkg
`default_nettype wire

// File: rtl/awgn_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : awgn_pair_fifo
//  Description : DEPTH-entry first-word-fall-through FIFO of bm_pair_t.
//                Push into a full FIFO is accepted only when a pop happens in
//                the same cycle. A pop on an empty FIFO is ignored; a push
//                into an empty FIFO appears at the head on the next cycle.
//                flush empties the FIFO and overrides push/pop.
//  Ports       : clk, rst (async, active-low), flush, push, din, pop,
//                dout (head, 0 when empty), level (0..DEPTH), empty,
//                push_acc (push was accepted this cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module awgn_pair_fifo
   import awgn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  bm_pair_t      din,
   input  logic          pop,
   output bm_pair_t      dout,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          push_acc
);

   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   bm_pair_t        mem_q [DEPTH];
   bm_pair_t        mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q,  level_d;
   logic            full;
   logic            pop_acc;

   assign empty    = (level_q == '0);
   assign full     = (level_q == FULL_LEVEL);
   assign pop_acc  = pop  && !empty && !flush;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_acc = push && !flush && (!full || pop_acc);

   assign level = level_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_acc) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;   // wraps modulo DEPTH
         end
         if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule : awgn_pair_fifo
`default_nettype wire

// File: rtl/urng_pair_packer.sv
`default_nettype none
// ============================================================================
//  Module      : urng_pair_packer
//  Description : Packs two successive 32-bit URNG words into one Box-Muller
//                pair (u0 = {word1, word2[31:16]}, u1 = word2[15:0]), forces
//                a zero u0 to 1, and buffers pairs in a FWFT FIFO with a
//                valid/ready output. Pairs that find the FIFO full (and no
//                simultaneous pop) are dropped and flag sticky overflow; the
//                packing phase never stalls.
//  Ports       : clk, rst (async, active-low), in_valid, in_data[31:0],
//                flush, out_valid, out_ready, u0[47:0], u1[15:0],
//                level[AW:0], overflow
//  Config      : URNG_PAIR_STATS_EN adds pair_cnt[31:0], drop_cnt[15:0] and
//                zero_cnt[15:0] (saturating, cleared by rst and flush).
//  Revision    : 1.0 - initial release
// ============================================================================
module urng_pair_packer
   import awgn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [URNG_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [U0_W-1:0]   u0,
   output logic [U1_W-1:0]   u1,
   output logic [AW:0]       level,
   output logic              overflow
`ifdef URNG_PAIR_STATS_EN
   ,
   output logic [31:0]       pair_cnt,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       zero_cnt
`endif
);

   pack_phase_t        phase_q, phase_d;
   logic [URNG_W-1:0]  hi_q,    hi_d;
   logic               overflow_q, overflow_d;

   logic               pair_done;
   logic [U0_W-1:0]    u0_raw;
   logic               zero_hit;
   bm_pair_t           pair_in;
   bm_pair_t           head;
   logic               fifo_empty;
   logic               push_acc;
   logic               pop;
   logic               drop;

   // ------------------------------------------------------------------
   // Pair assembly and zero guard
   // ------------------------------------------------------------------
   assign pair_done  = in_valid && (phase_q == PH_LO) && !flush;
   assign u0_raw     = {hi_q, in_data[URNG_W-1:U1_W]};
   assign zero_hit   = pair_done && (u0_raw == '0);
   assign pair_in.u0 = u0_guard(u0_raw);
   assign pair_in.u1 = in_data[U1_W-1:0];

   assign pop        = out_valid && out_ready;
   // The FIFO refuses the push only when full without a same-cycle pop.
   assign drop       = pair_done && !push_acc;

   awgn_pair_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (pair_done),
      .din      (pair_in),
      .pop      (pop),
      .dout     (head),
      .level    (level),
      .empty    (fifo_empty),
      .push_acc (push_acc)
   );

   assign out_valid = !fifo_empty;
   assign u0        = head.u0;
   assign u1        = head.u1;
   assign overflow  = overflow_q;

   // ------------------------------------------------------------------
   // Phase FSM and high-word register
   // ------------------------------------------------------------------
   always_comb begin
      phase_d    = phase_q;
      hi_d       = hi_q;
      overflow_d = overflow_q | drop;
      if (flush) begin
         phase_d = PH_HI;
         hi_d    = '0;
      end else if (in_valid) begin
         case (phase_q)
            PH_HI: begin
               phase_d = PH_LO;
               hi_d    = in_data;
            end
            PH_LO: begin
               phase_d = PH_HI;
            end
            default: begin
               phase_d = PH_HI;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q    <= PH_HI;
         hi_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         hi_q       <= hi_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef URNG_PAIR_STATS_EN
   // ------------------------------------------------------------------
   // Saturating statistics counters
   // ------------------------------------------------------------------
   logic [31:0] pair_cnt_q, pair_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [15:0] zero_cnt_q, zero_cnt_d;

   always_comb begin
      pair_cnt_d = pair_cnt_q;
      drop_cnt_d = drop_cnt_q;
      zero_cnt_d = zero_cnt_q;
      if (flush) begin
         pair_cnt_d = '0;
         drop_cnt_d = '0;
         zero_cnt_d = '0;
      end else begin
         if (push_acc && (pair_cnt_q != '1)) pair_cnt_d = pair_cnt_q + 32'd1;
         if (drop     && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
         if (zero_hit && (zero_cnt_q != '1)) zero_cnt_d = zero_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pair_cnt_q <= '0;
         drop_cnt_q <= '0;
         zero_cnt_q <= '0;
      end else begin
         pair_cnt_q <= pair_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign pair_cnt = pair_cnt_q;
   assign drop_cnt = drop_cnt_q;
   assign zero_cnt = zero_cnt_q;
`else
   // zero_hit only feeds the statistics counters.
   logic unused_zero_hit;
   assign unused_zero_hit = zero_hit;
`endif

endmodule : urng_pair_packer
`default_nettype wire

// File: tb/tb_urng_pair_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_urng_pair_packer
//  Description : Self-checking bench for urng_pair_packer (DEPTH = 4).
//                Table of single-cycle vectors plus hand-written sequences
//                for full/overflow, push+pop at full, flush and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_urng_pair_packer;
   import awgn_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [47:0]       u0;
   logic [15:0]       u1;
   logic [AW:0]       level;
   logic              overflow;
`ifdef URNG_PAIR_STATS_EN
   logic [31:0]       pair_cnt;
   logic [15:0]       drop_cnt;
   logic [15:0]       zero_cnt;
`endif

   int checks = 0;
   int errors = 0;

   urng_pair_packer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .u0        (u0),
      .u1        (u1),
      .level     (level),
      .overflow  (overflow)
`ifdef URNG_PAIR_STATS_EN
      ,
      .pair_cnt  (pair_cnt),
      .drop_cnt  (drop_cnt),
      .zero_cnt  (zero_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        rdy;
      logic        fl;
      logic        e_valid;
      logic [47:0] e_u0;
      logic [15:0] e_u1;
      int          e_level;
      logic        e_ovf;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [47:0] eu0,
                            input logic [15:0] eu1, input int elev, input logic eovf);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".u0"},        64'(u0),        64'(eu0));
      check({tag, ".u1"},        64'(u1),        64'(eu1));
      check({tag, ".level"},     64'(level),     64'(elev));
      check({tag, ".overflow"},  64'(overflow),  64'(eovf));
   endtask

   // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic iv, input logic [31:0] d, input logic rdy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] word_of(input int k);
      return 32'h1000_0000 + 32'(k) * 32'h0001_1111;
   endfunction

   function automatic logic [47:0] exp_u0(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] r;
      r = {a, b[31:16]};
      return (r == 48'd0) ? 48'd1 : r;
   endfunction

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

      //              iv  data          rdy fl  valid u0               u1       lvl ovf
      vecs[0] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 48'h0,            16'h0,    0, 1'b0};
      vecs[1] = '{1'b1, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 48'h123456789ABC, 16'hDEF0, 1, 1'b0};
      vecs[2] = '{1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 48'h0,            16'h0,    0, 1'b0};
      // empty FIFO: push with out_ready=1 stores the pair, no bypass
      vecs[3] = '{1'b1, 32'h0000ABCD, 1'b1, 1'b0, 1'b1, 48'h1,            16'hABCD, 1, 1'b0};
      vecs[4] = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 48'h0,            16'h0,    0, 1'b0};
      vecs[5] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 48'h0,            16'h0,    0, 1'b0};
      // flush ignores this word and returns the phase to HI
      vecs[6] = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 48'h0,            16'h0,    0, 1'b0};
      vecs[7] = '{1'b1, 32'hAAAA0000, 1'b0, 1'b0, 1'b0, 48'h0,            16'h0,    0, 1'b0};
      vecs[8] = '{1'b1, 32'h5555FFFF, 1'b0, 1'b0, 1'b1, 48'hAAAA00005555, 16'hFFFF, 1, 1'b0};
      vecs[9] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 48'h0,            16'h0,    0, 1'b0};

      // Reset state
      @(posedge clk); #1;
      check_all("reset", 1'b0, 48'h0, 16'h0, 0, 1'b0);
      #3 rst = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].fl);
         check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_u0,
                   vecs[i].e_u1, vecs[i].e_level, vecs[i].e_ovf);
`ifdef URNG_PAIR_STATS_EN
         if (i == 3) check("zero_cnt", 64'(zero_cnt), 64'd1);
`endif
      end

      // Fill with out_ready=0: 2*DEPTH+2 words -> DEPTH pairs kept, 5th dropped
      for (int k = 0; k < 2*DEPTH+2; k++) begin
         step(1'b1, word_of(k), 1'b0, 1'b0);
         if (k == 2*DEPTH-1) begin
            check("fill.level_at_full", 64'(level), 64'(DEPTH));
            check("fill.ovf_at_full",   64'(overflow), 64'd0);
         end
      end
      check_all("overflow", 1'b1, exp_u0(word_of(0), word_of(1)), word_of(1)[15:0], DEPTH, 1'b1);
      // Head holds while not ready
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check_all("hold", 1'b1, exp_u0(word_of(0), word_of(1)), word_of(1)[15:0], DEPTH, 1'b1);
      // Flush with data present: FIFO empties, overflow stays sticky
      step(1'b0, 32'h0, 1'b1, 1'b1);
      check_all("flush_full", 1'b0, 48'h0, 16'h0, 0, 1'b1);

      // Full FIFO, pop on pair-completion cycle -> level stays DEPTH, no overflow
      do_reset();
      for (int k = 0; k < 2*DEPTH+1; k++) begin
         step(1'b1, word_of(k), 1'b0, 1'b0);
      end
      check("pp.level_before", 64'(level), 64'(DEPTH));
      step(1'b1, word_of(2*DEPTH+1), 1'b1, 1'b0);
      check_all("pushpop", 1'b1, exp_u0(word_of(2), word_of(3)), word_of(3)[15:0], DEPTH, 1'b0);
      // Drain and confirm the pair pushed on the full cycle reached the tail
      for (int p = 0; p < DEPTH-1; p++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      check_all("pp.tail", 1'b1, exp_u0(word_of(2*DEPTH), word_of(2*DEPTH+1)),
                word_of(2*DEPTH+1)[15:0], 1, 1'b0);

      // Async reset mid-stream after an odd word count
      do_reset();
      step(1'b1, 32'hCAFEBABE, 1'b0, 1'b0);
      step(1'b1, 32'h01234567, 1'b0, 1'b0);
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);   // partial hi pending
      check("mid.level", 64'(level), 64'd1);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 48'h0, 16'h0, 0, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 32'h76543210, 1'b0, 1'b0);
      step(1'b1, 32'hFEDCBA98, 1'b0, 1'b0);
      check_all("restart", 1'b1, 48'h76543210FEDC, 16'hBA98, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_urng_pair_packer
`default_nettype wire
